// File: rtl/att_feeder_pkg.sv
// Shared definitions for the attention-core feeder: default geometry,
// FSM state encoding and a counter-width helper.
package att_feeder_pkg;

    localparam int ATT_WIDTH = 8;
    localparam int ATT_N_TOK = 4;
    localparam int ATT_N_RES = 4;
    localparam int ATT_TMO   = 255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_WAIT,
        ST_DRAIN
    } state_t;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/att_feeder.sv
// Buffers one pass of tokens, streams them into the attention core, collects
// its results (with a watchdog) and drains them downstream in capture order.
module att_feeder
    import att_feeder_pkg::*;
#(
    parameter int W     = ATT_WIDTH,
    parameter int N_TOK = ATT_N_TOK,
    parameter int N_RES = ATT_N_RES,
    parameter int TMO   = ATT_TMO
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    input  logic [W-1:0] s_bias,
    output logic         core_en,
    output logic [W-1:0] core_att,
    output logic [W-1:0] core_bias,
    input  logic         core_end,
    input  logic [W-1:0] core_res,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data,
    output logic         m_last,
    output logic         busy,
    output logic         err
);

    localparam int IW  = cnt_w(N_TOK - 1);
    localparam int RIW = cnt_w(N_RES - 1);
    localparam int RCW = cnt_w(N_RES);
    localparam int TW  = cnt_w(TMO);

    localparam logic [IW-1:0]  TOK_LAST = IW'(N_TOK - 1);
    localparam logic [RCW-1:0] RES_FULL = RCW'(N_RES);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TMO - 1);

    state_t           state_q, state_d;
    logic [IW-1:0]    wr_idx_q, wr_idx_d;
    logic [IW-1:0]    rd_idx_q, rd_idx_d;
    logic [RCW-1:0]   res_cnt_q, res_cnt_d;
    logic [RIW-1:0]   out_idx_q, out_idx_d;
    logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic             err_q, err_d;
    logic [W-1:0]     tok_att_q  [N_TOK];
    logic [W-1:0]     tok_att_d  [N_TOK];
    logic [W-1:0]     tok_bias_q [N_TOK];
    logic [W-1:0]     tok_bias_d [N_TOK];
    logic [W-1:0]     res_q      [N_RES];
    logic [W-1:0]     res_d      [N_RES];

    logic s_hs;
    logic m_hs;
    logic capture;

    // s_ready is gated by rstn so upstream sees no acceptance while held in reset.
    always_comb begin
        s_ready   = rstn && ((state_q == ST_IDLE) || (state_q == ST_LOAD));
        core_en   = (state_q == ST_RUN) || (state_q == ST_WAIT);
        core_att  = '0;
        core_bias = '0;
        if (state_q == ST_RUN) begin
            core_att  = tok_att_q[rd_idx_q];
            core_bias = tok_bias_q[rd_idx_q];
        end else if (state_q == ST_WAIT) begin
            core_att  = tok_att_q[TOK_LAST];
            core_bias = tok_bias_q[TOK_LAST];
        end
        m_valid = (state_q == ST_DRAIN) && (res_cnt_q != '0);
        m_data  = m_valid ? res_q[out_idx_q] : '0;
        m_last  = m_valid && ((RCW'(out_idx_q) + RCW'(1)) == res_cnt_q);
        busy    = (state_q != ST_IDLE);
        err     = err_q;
        s_hs    = s_valid && s_ready;
        m_hs    = m_valid && m_ready;
        capture = core_en && core_end && (res_cnt_q != RES_FULL);
    end

    always_comb begin
        state_d    = state_q;
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        res_cnt_d  = res_cnt_q;
        out_idx_d  = out_idx_q;
        tmo_cnt_d  = tmo_cnt_q;
        err_d      = err_q;
        tok_att_d  = tok_att_q;
        tok_bias_d = tok_bias_q;
        res_d      = res_q;

        if (capture) begin
            res_d[RIW'(res_cnt_q)] = core_res;
            res_cnt_d              = res_cnt_q + RCW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (s_hs) begin
                    tok_att_d[0]  = s_data;
                    tok_bias_d[0] = s_bias;
                    err_d         = 1'b0;
                    res_cnt_d     = '0;
                    out_idx_d     = '0;
                    rd_idx_d      = '0;
                    if (N_TOK == 1) begin
                        state_d = ST_RUN;
                    end else begin
                        wr_idx_d = IW'(1);
                        state_d  = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (s_hs) begin
                    tok_att_d[wr_idx_q]  = s_data;
                    tok_bias_d[wr_idx_q] = s_bias;
                    if (wr_idx_q == TOK_LAST) begin
                        wr_idx_d = '0;
                        rd_idx_d = '0;
                        state_d  = ST_RUN;
                    end else begin
                        wr_idx_d = wr_idx_q + IW'(1);
                    end
                end
            end
            ST_RUN: begin
                if (rd_idx_q == TOK_LAST) begin
                    tmo_cnt_d = '0;
                    state_d   = ST_WAIT;
                end else begin
                    rd_idx_d = rd_idx_q + IW'(1);
                end
                // A full result set ends the pass even if tokens remain unfed.
                if (res_cnt_d == RES_FULL) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_WAIT: begin
                if (capture) begin
                    tmo_cnt_d = '0;
                    if (res_cnt_d == RES_FULL) begin
                        state_d = ST_DRAIN;
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_DRAIN;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            ST_DRAIN: begin
                rd_idx_d  = '0;
                tmo_cnt_d = '0;
                if (res_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else if (m_hs) begin
                    if (m_last) begin
                        out_idx_d = '0;
                        res_cnt_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        out_idx_d = out_idx_q + RIW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            res_cnt_q  <= '0;
            out_idx_q  <= '0;
            tmo_cnt_q  <= '0;
            err_q      <= 1'b0;
            tok_att_q  <= '{default: '0};
            tok_bias_q <= '{default: '0};
            res_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            res_cnt_q  <= res_cnt_d;
            out_idx_q  <= out_idx_d;
            tmo_cnt_q  <= tmo_cnt_d;
            err_q      <= err_d;
            tok_att_q  <= tok_att_d;
            tok_bias_q <= tok_bias_d;
            res_q      <= res_d;
        end
    end

endmodule

// File: tb/tb_att_feeder.sv
// Directed bench for att_feeder: load/run, result drain with stalls, timeouts,
// and reset in the middle of a pass.
module tb_att_feeder;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = '0;
    logic [7:0] s_bias = '0;
    logic       core_en;
    logic [7:0] core_att;
    logic [7:0] core_bias;
    logic       core_end = 1'b0;
    logic [7:0] core_res = '0;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic       m_last;
    logic       busy;
    logic       err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    att_feeder #(.W(8), .N_TOK(4), .N_RES(4), .TMO(8)) dut (
        .clk(clk), .rstn(rstn),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_bias(s_bias),
        .core_en(core_en), .core_att(core_att), .core_bias(core_bias),
        .core_end(core_end), .core_res(core_res),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .err(err)
    );

    // Presents four tokens back-to-back; returns on the first RUN-cycle negedge.
    task automatic load_pass(input logic [31:0] toks, input logic [31:0] biases);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = toks[8*i +: 8];
            s_bias  = biases[8*i +: 8];
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_data  = '0;
        s_bias  = '0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({s_ready, core_en, m_valid, m_last, err, busy} !== 6'b000000) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {s_ready, core_en, m_valid, m_last, err, busy});
        end
        rstn = 1'b1;
        @(negedge clk);
        vectors++;
        if ({s_ready, busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_release: s_ready/busy got %b expected 10", {s_ready, busy});
        end
        $display("test_reset done");
    endtask

    task automatic test_run();
        load_pass(32'h04030201, 32'h0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            vectors++;
            if ({core_en, s_ready, core_att, core_bias} !== {1'b1, 1'b0, 8'(i + 1), 8'h00}) begin
                miscompares++;
                $display("FAIL run_cycle%0d: en/rdy/att/bias got %b/%b/%0d/%0d expected 1/0/%0d/0",
                         i, core_en, s_ready, core_att, core_bias, i + 1);
            end
        end
        $display("test_run done");
    endtask

    task automatic test_results_stall();
        logic [7:0] exp_r [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
        int stall;
        @(negedge clk);
        vectors++;
        if ({core_en, core_att, busy, m_valid} !== {1'b1, 8'd4, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL wait_hold: en/att/busy/mv got %b/%0d/%b/%b expected 1/4/1/0",
                     core_en, core_att, busy, m_valid);
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            core_end = 1'b1;
            core_res = exp_r[i];
        end
        @(negedge clk);
        core_end = 1'b0;
        core_res = '0;
        for (int k = 0; k < 4; k++) begin
            stall = (k == 1) ? 3 : 0;
            for (int s = 0; s < stall; s++) begin
                m_ready = 1'b0;
                vectors++;
                if ({m_valid, m_data, m_last} !== {1'b1, exp_r[k], 1'b0}) begin
                    miscompares++;
                    $display("FAIL stall_hold%0d: valid/data/last got %b/%0d/%b expected 1/%0d/0",
                             s, m_valid, m_data, m_last, exp_r[k]);
                end
                @(negedge clk);
            end
            vectors++;
            if ({m_valid, m_data, m_last} !== {1'b1, exp_r[k], k == 3}) begin
                miscompares++;
                $display("FAIL drain%0d: valid/data/last got %b/%0d/%b expected 1/%0d/%b",
                         k, m_valid, m_data, m_last, exp_r[k], k == 3);
            end
            m_ready = 1'b1;
            @(negedge clk);
        end
        m_ready = 1'b0;
        vectors++;
        if ({busy, m_valid, s_ready, err} !== 4'b0010) begin
            miscompares++;
            $display("FAIL pass_end: busy/mv/rdy/err got %b expected 0010",
                     {busy, m_valid, s_ready, err});
        end
        $display("test_results_stall done");
    endtask

    task automatic test_timeout_zero();
        load_pass(32'h08070605, 32'h04030201);
        vectors++;
        if ({core_att, core_bias} !== {8'd5, 8'd1}) begin
            miscompares++;
            $display("FAIL run_bias: att/bias got %0d/%0d expected 5/1", core_att, core_bias);
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vectors++;
            if ({err, m_valid, core_en} !== 3'b001) begin
                miscompares++;
                $display("FAIL tmo_wait%0d: err/mv/en got %b expected 001", i, {err, m_valid, core_en});
            end
        end
        @(negedge clk);
        vectors++;
        if ({err, m_valid, core_en, busy, core_att} !== {4'b1001, 8'd0}) begin
            miscompares++;
            $display("FAIL tmo_drain: err/mv/en/busy/att got %b/%0d expected 1001/0",
                     {err, m_valid, core_en, busy}, core_att);
        end
        @(negedge clk);
        vectors++;
        if ({busy, err, s_ready, m_valid} !== 4'b0110) begin
            miscompares++;
            $display("FAIL tmo_idle: busy/err/rdy/mv got %b expected 0110",
                     {busy, err, s_ready, m_valid});
        end
        $display("test_timeout_zero done");
    endtask

    task automatic test_timeout_partial();
        load_pass(32'h0D0C0B0A, 32'h0);
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_clear: err got %b expected 0", err);
        end
        repeat (4) @(negedge clk);
        core_end = 1'b1;
        core_res = 8'h55;
        @(negedge clk);
        core_res = 8'h66;
        @(negedge clk);
        core_end = 1'b0;
        core_res = '0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            vectors++;
            if ({err, m_valid, core_en} !== 3'b001) begin
                miscompares++;
                $display("FAIL part_wait%0d: err/mv/en got %b expected 001", i, {err, m_valid, core_en});
            end
        end
        @(negedge clk);
        vectors++;
        if ({err, m_valid, m_data, m_last} !== {1'b1, 1'b1, 8'h55, 1'b0}) begin
            miscompares++;
            $display("FAIL part_res0: err/mv/data/last got %b/%b/%h/%b expected 1/1/55/0",
                     err, m_valid, m_data, m_last);
        end
        m_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if ({m_valid, m_data, m_last} !== {1'b1, 8'h66, 1'b1}) begin
            miscompares++;
            $display("FAIL part_res1: mv/data/last got %b/%h/%b expected 1/66/1",
                     m_valid, m_data, m_last);
        end
        @(negedge clk);
        m_ready = 1'b0;
        vectors++;
        if ({busy, m_valid, err} !== 3'b001) begin
            miscompares++;
            $display("FAIL part_idle: busy/mv/err got %b expected 001", {busy, m_valid, err});
        end
        $display("test_timeout_partial done");
    endtask

    task automatic test_reset_mid();
        load_pass(32'h04030201, 32'h0);
        repeat (4) @(negedge clk);
        core_end = 1'b1;
        core_res = 8'h77;
        @(negedge clk);
        core_end = 1'b0;
        core_res = '0;
        rstn     = 1'b0;
        #1;
        vectors++;
        if ({core_en, m_valid, busy, s_ready} !== 4'b0000) begin
            miscompares++;
            $display("FAIL mid_reset: en/mv/busy/rdy got %b expected 0000",
                     {core_en, m_valid, busy, s_ready});
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        vectors++;
        if ({busy, m_valid, s_ready} !== 3'b001) begin
            miscompares++;
            $display("FAIL mid_idle: busy/mv/rdy got %b expected 001", {busy, m_valid, s_ready});
        end
        // Results arrive during RUN; the aborted pass's capture must not reappear.
        load_pass(32'h24232221, 32'h34333231);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            vectors++;
            if ({core_en, core_att, core_bias} !== {1'b1, 8'(8'h21 + i), 8'(8'h31 + i)}) begin
                miscompares++;
                $display("FAIL rerun%0d: en/att/bias got %b/%h/%h expected 1/%h/%h",
                         i, core_en, core_att, core_bias, 8'h21 + i, 8'h31 + i);
            end
            core_end = 1'b1;
            core_res = 8'(8'h91 + i);
        end
        @(negedge clk);
        core_end = 1'b0;
        core_res = '0;
        m_ready  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            vectors++;
            if ({m_valid, m_data, m_last, core_en} !== {1'b1, 8'(8'h91 + k), k == 3, 1'b0}) begin
                miscompares++;
                $display("FAIL rerun_drain%0d: mv/data/last/en got %b/%h/%b/%b expected 1/%h/%b/0",
                         k, m_valid, m_data, m_last, core_en, 8'h91 + k, k == 3);
            end
        end
        @(negedge clk);
        m_ready = 1'b0;
        vectors++;
        if ({busy, m_valid, err} !== 3'b000) begin
            miscompares++;
            $display("FAIL rerun_idle: busy/mv/err got %b expected 000", {busy, m_valid, err});
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_run();
        test_results_stall();
        test_timeout_zero();
        test_timeout_partial();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/att_feeder.md
ATT_FEEDER -- requirements
Module: att_feeder

Interface
REQ-001 Parameter W, default att_width, token/bias/result width in bits.
REQ-002 Parameter N_TOK, default 4, tokens per attention pass.
REQ-003 Parameter N_RES, default 4, results collected per pass.
REQ-004 Parameter TMO, default 255, maximum WAIT cycles between captures.
REQ-005 clk  input  1  clock, rising edge.
REQ-006 rstn  input  1  reset, asynchronous, active-low.
REQ-007 s_valid  input  1  upstream token valid.
REQ-008 s_ready  output  1  feeder accepts token.
REQ-009 s_data  input  W  token value.
REQ-010 s_bias  input  W  bias paired with token.
REQ-011 core_en  output  1  enable to attention core.
REQ-012 core_att  output  W  token to core.
REQ-013 core_bias  output  W  bias to core.
REQ-014 core_end  input  1  core result-valid flag.
REQ-015 core_res  input  W  core result.
REQ-016 m_valid  output  1  result valid downstream.
REQ-017 m_ready  input  1  downstream accepts result.
REQ-018 m_data  output  W  result value.
REQ-019 m_last  output  1  final result of pass.
REQ-020 busy  output  1  high in any state except IDLE.
REQ-021 err  output  1  sticky timeout flag, cleared on next accepted token in IDLE.

Function
REQ-022 FSM states IDLE, LOAD, RUN, WAIT, DRAIN; one state register.
REQ-023 IDLE: s_ready=1; token accepted on s_valid&s_ready, stored at index 0, go LOAD (or RUN if N_TOK=1).
REQ-024 LOAD: s_ready=1; each handshake stores s_data/s_bias at write index and increments index; Nth accept goes RUN next cycle.
REQ-025 RUN: s_ready=0, core_en=1, core_att/core_bias = buffer[rd_idx]; rd_idx 0..N_TOK-1, one token per cycle, N_TOK cycles, then WAIT.
REQ-026 WAIT: core_en stays 1; core_att/core_bias hold last token; each cycle with core_end=1 writes core_res to result buffer and increments res count.
REQ-027 core_end during RUN is also captured (same rule as WAIT).
REQ-028 res count reaching N_RES: go DRAIN next cycle; further core_end ignored.
REQ-029 Timeout counter clears on each capture and on WAIT entry; reaching TMO cycles without capture sets err and goes DRAIN with captured count.
REQ-030 DRAIN: core_en=0, core_att=core_bias=0; m_valid=1 while results remain, m_data=result[idx] in capture order.
REQ-031 m_last=1 with final result; handshake m_valid&m_ready on m_last returns to IDLE.
REQ-032 m_data/m_valid held stable while m_valid=1 and m_ready=0.
REQ-033 Timeout with zero captures: DRAIN emits nothing, returns to IDLE next cycle; err=1.
REQ-034 core_en low in IDLE, LOAD, DRAIN; guarantees core counter clear between passes.
REQ-035 No arithmetic on data; counters sized $clog2(max+1).

Reset
REQ-036 rstn low: state IDLE, all indices/counters 0, buffers 0, core_en=0, m_valid=0, m_last=0, err=0, s_ready=0 during reset, 1 in IDLE after.
REQ-037 Reset mid-pass aborts immediately; no partial results emitted afterwards.

Structure
REQ-038 FSM state enum and defaults for W, N_TOK, N_RES, TMO live in package definition.
REQ-039 Single module; token/bias and result buffers are internal register arrays, no sub-modules.

Verification
REQ-040 Load 4 tokens 1,2,3,4 bias 0 back-to-back -> core_att 1,2,3,4 on 4 consecutive RUN cycles with core_en=1.
REQ-041 Model core returns 10,20,30,40 on core_end -> m_data 10,20,30,40, m_last with 40, busy falls after last handshake.
REQ-042 m_ready low 3 cycles on second result -> m_data stays 20 with m_valid=1, no loss.
REQ-043 core_end never asserted, TMO=8 -> err=1 after 8 WAIT cycles, no m_valid, back to IDLE.
REQ-044 Two core_end then silence, TMO=8 -> 2 results emitted, m_last on second, err=1.
REQ-045 rstn pulsed during WAIT -> core_en=0, m_valid=0, IDLE; next pass runs normally.
